// File: rtl/connect4_pkg.sv
`default_nettype none
// ======================================================================
// connect4_pkg -- Connect4 types and constants shared by turn ctrl, board
// and win checker.                                              Rev 1.0
// ======================================================================
package connect4_pkg;

  localparam int ROWS      = 6;
  localparam int COLS      = 7;
  localparam int MAX_MOVES = 42;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    WAIT_MOVE = 3'd0,
    WRITE     = 3'd1,
    CHECK     = 3'd2,
    DONE      = 3'd3,
    CLEAR     = 3'd4
  } turn_state_t;

  // Lowest-index column whose bit in `full` is clear.
  function automatic logic [2:0] first_free_col(input logic [COLS-1:0] full);
    first_free_col = 3'd0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!full[i]) first_free_col = 3'(i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/connect4_btn_sync.sv
`default_nettype none
// ======================================================================
// connect4_btn_sync -- 2-flop synchronizer plus rising-edge pulse for an
// asynchronous button.                                          Rev 1.0
// ======================================================================
module connect4_btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign press_o = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/connect4_turn_ctrl.sv
`default_nettype none
// ======================================================================
// connect4_turn_ctrl -- Connect4 turn sequencer: drop legality, board
// write, win-check trigger, timeout auto-move, draw, clear.     Rev 1.0
// ======================================================================
module connect4_turn_ctrl #(
  parameter int unsigned TURN_TIMEOUT = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] column,
  input  logic       load_btn,
  output logic       wr_req,
  output logic [2:0] wr_row,
  output logic [2:0] wr_col,
  output logic [1:0] wr_val,
  input  logic       wr_ack,
  output logic       clr_req,
  input  logic       clr_ack,
  output logic       chk_start,
  input  logic       chk_done,
  input  logic       chk_win,
  output logic [1:0] cur_player,
  output logic [5:0] move_count,
  output logic       illegal,
  output logic       timeout,
  output logic       game_over,
  output logic [1:0] winner
);

  import connect4_pkg::*;

  localparam int          TMR_W    = (TURN_TIMEOUT > 0) ? $clog2(TURN_TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = (TURN_TIMEOUT > 0) ? TMR_W'(TURN_TIMEOUT - 1) : '0;
  localparam logic        TMR_EN   = (TURN_TIMEOUT > 0);

  turn_state_t                state_q, state_d;
  logic [COLS-1:0][2:0]       heights_q, heights_d;
  logic [5:0]                 count_q, count_d;
  logic [TMR_W-1:0]           timer_q, timer_d;
  logic [2:0]                 row_q, row_d;
  logic [2:0]                 col_q, col_d;
  cell_t                      val_q, val_d;
  cell_t                      player_q, player_d;
  cell_t                      winner_q, winner_d;
  logic                       illegal_q, illegal_d;
  logic                       timeout_q, timeout_d;
  logic                       chk_start_q, chk_start_d;

  logic                       press;
  logic [COLS-1:0]            full;
  logic [7:0]                 full_ext;
  logic [2:0]                 auto_col;
  logic                       expired;

  connect4_btn_sync u_btn_sync (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (load_btn),
    .press_o (press)
  );

  always_comb begin
    full = '0;
    for (int i = 0; i < COLS; i++) begin
      full[i] = (heights_q[i] == 3'(ROWS));
    end
  end

  // Column code 7 is treated as a permanently full column.
  assign full_ext = {1'b1, full};
  assign auto_col = first_free_col(full);
  assign expired  = TMR_EN && (timer_q == TMR_LAST);

  always_comb begin
    state_d     = state_q;
    heights_d   = heights_q;
    count_d     = count_q;
    timer_d     = timer_q;
    row_d       = row_q;
    col_d       = col_q;
    val_d       = val_q;
    player_d    = player_q;
    winner_d    = winner_q;
    illegal_d   = 1'b0;
    timeout_d   = 1'b0;
    chk_start_d = 1'b0;

    unique case (state_q)
      WAIT_MOVE: begin
        if (timer_q != TMR_LAST) timer_d = timer_q + TMR_W'(1);
        if (press) begin
          if (full_ext[column]) begin
            illegal_d = 1'b1;
          end else begin
            col_d   = column;
            row_d   = heights_q[column];
            val_d   = player_q;
            state_d = WRITE;
          end
        end else if (expired) begin
          timeout_d = 1'b1;
          col_d     = auto_col;
          row_d     = heights_q[auto_col];
          val_d     = player_q;
          state_d   = WRITE;
        end
      end

      WRITE: begin
        if (wr_ack) begin
          heights_d[col_q] = heights_q[col_q] + 3'd1;
          count_d          = count_q + 6'd1;
          chk_start_d      = 1'b1;
          state_d          = CHECK;
        end
      end

      // chk_done is only meaningful after the start pulse has been seen.
      CHECK: begin
        if (chk_done && !chk_start_q) begin
          if (chk_win) begin
            winner_d = player_q;
            state_d  = DONE;
          end else if (count_q == 6'(MAX_MOVES)) begin
            winner_d = EMPTY;
            state_d  = DONE;
          end else begin
            player_d = (player_q == P1) ? P2 : P1;
            timer_d  = '0;
            state_d  = WAIT_MOVE;
          end
        end
      end

      DONE: begin
        if (press) state_d = CLEAR;
      end

      CLEAR: begin
        if (clr_ack) begin
          heights_d = '0;
          count_d   = '0;
          winner_d  = EMPTY;
          player_d  = P1;
          timer_d   = '0;
          state_d   = WAIT_MOVE;
        end
      end

      default: state_d = WAIT_MOVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= WAIT_MOVE;
      heights_q   <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      val_q       <= EMPTY;
      player_q    <= P1;
      winner_q    <= EMPTY;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
      chk_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      heights_q   <= heights_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      row_q       <= row_d;
      col_q       <= col_d;
      val_q       <= val_d;
      player_q    <= player_d;
      winner_q    <= winner_d;
      illegal_q   <= illegal_d;
      timeout_q   <= timeout_d;
      chk_start_q <= chk_start_d;
    end
  end

  assign wr_req     = (state_q == WRITE);
  assign clr_req    = (state_q == CLEAR);
  assign game_over  = (state_q == DONE);
  assign wr_row     = row_q;
  assign wr_col     = col_q;
  assign wr_val     = val_q;
  assign cur_player = player_q;
  assign winner     = winner_q;
  assign move_count = count_q;
  assign illegal    = illegal_q;
  assign timeout    = timeout_q;
  assign chk_start  = chk_start_q;

endmodule
`default_nettype wire

// File: tb/tb_connect4_turn_ctrl.sv
`default_nettype none
// ======================================================================
// tb_connect4_turn_ctrl -- directed self-checking bench for the Connect4
// turn sequencer.                                               Rev 1.0
// ======================================================================
module tb_connect4_turn_ctrl;

  localparam int unsigned TO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] column = 3'd0;
  logic       load_btn = 1'b0;
  logic       wr_ack = 1'b0;
  logic       clr_ack = 1'b0;
  logic       chk_done = 1'b0;
  logic       chk_win = 1'b0;

  logic       wr_req;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic [1:0] wr_val;
  logic       clr_req;
  logic       chk_start;
  logic [1:0] cur_player;
  logic [5:0] move_count;
  logic       illegal;
  logic       timeout;
  logic       game_over;
  logic [1:0] winner;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  connect4_turn_ctrl #(.TURN_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .column     (column),
    .load_btn   (load_btn),
    .wr_req     (wr_req),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_val     (wr_val),
    .wr_ack     (wr_ack),
    .clr_req    (clr_req),
    .clr_ack    (clr_ack),
    .chk_start  (chk_start),
    .chk_done   (chk_done),
    .chk_win    (chk_win),
    .cur_player (cur_player),
    .move_count (move_count),
    .illegal    (illegal),
    .timeout    (timeout),
    .game_over  (game_over),
    .winner     (winner)
  );

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset();
    rst = 1'b0; load_btn = 1'b0; wr_ack = 1'b0; clr_ack = 1'b0;
    chk_done = 1'b0; chk_win = 1'b0; column = 3'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Returns at the negedge just after the FSM has reacted to the press.
  task automatic press_btn(input logic [2:0] col);
    @(negedge clk); column = col; load_btn = 1'b1;
    @(negedge clk); load_btn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic ack_write();
    wr_ack = 1'b1;
    @(negedge clk); wr_ack = 1'b0;
  endtask

  task automatic finish_check(input logic win);
    @(negedge clk); chk_done = 1'b1; chk_win = win;
    @(negedge clk); chk_done = 1'b0; chk_win = 1'b0;
  endtask

  task automatic do_move(input logic [2:0] col, input logic win);
    press_btn(col);
    ack_write();
    finish_check(win);
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (cur_player !== 2'b01) begin errors++; $display("FAIL rst_player: got %b want 01", cur_player); end
    vectors++; if (winner !== 2'b00) begin errors++; $display("FAIL rst_winner: got %b want 00", winner); end
    vectors++; if ({wr_row, wr_col, wr_val} !== 8'h00) begin errors++; $display("FAIL rst_fields: got %h want 00", {wr_row, wr_col, wr_val}); end
    vectors++; if ({wr_req, clr_req, chk_start, illegal, timeout, game_over} !== 6'b0) begin errors++;
      $display("FAIL rst_strobes: got %b want 000000", {wr_req, clr_req, chk_start, illegal, timeout, game_over}); end
    vectors++; if (move_count !== 6'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", move_count); end
  endtask

  task automatic test_first_move();
    apply_reset();
    press_btn(3'd3);
    vectors++; if (wr_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", wr_req); end
    vectors++; if ({wr_row, wr_col, wr_val} !== {3'd0, 3'd3, 2'b01}) begin errors++;
      $display("FAIL first_fields: got %h want %h", {wr_row, wr_col, wr_val}, {3'd0, 3'd3, 2'b01}); end
    ack_write();
    vectors++; if ({chk_start, wr_req} !== 2'b10) begin errors++; $display("FAIL first_chk_start: got %b want 10", {chk_start, wr_req}); end
    vectors++; if (move_count !== 6'd1) begin errors++; $display("FAIL first_count: got %0d want 1", move_count); end
    vectors++; if (cur_player !== 2'b01) begin errors++; $display("FAIL first_player_in_check: got %b want 01", cur_player); end
    finish_check(1'b0);
    vectors++; if (cur_player !== 2'b10) begin errors++; $display("FAIL first_player_after: got %b want 10", cur_player); end
    vectors++; if ({chk_start, game_over} !== 2'b00) begin errors++; $display("FAIL first_after_flags: got %b want 00", {chk_start, game_over}); end
  endtask

  task automatic test_column_fill();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      press_btn(3'd0);
      vectors++; if ({wr_req, wr_row, wr_col, wr_val} !== {1'b1, 3'(i), 3'd0, (i % 2 == 0) ? 2'b01 : 2'b10}) begin errors++;
        $display("FAIL fill_write%0d: got req=%b row=%0d col=%0d val=%b want row=%0d", i, wr_req, wr_row, wr_col, wr_val, i); end
      ack_write();
      finish_check(1'b0);
    end
    press_btn(3'd0);
    vectors++; if ({illegal, wr_req} !== 2'b10) begin errors++; $display("FAIL full_col_illegal: got illegal,req=%b want 10", {illegal, wr_req}); end
    vectors++; if (cur_player !== 2'b01) begin errors++; $display("FAIL full_col_player: got %b want 01", cur_player); end
    @(negedge clk);
    vectors++; if ({illegal, wr_req} !== 2'b00) begin errors++; $display("FAIL illegal_pulse_width: got %b want 00", {illegal, wr_req}); end
    press_btn(3'd7);
    vectors++; if ({illegal, wr_req} !== 2'b10) begin errors++; $display("FAIL col7_illegal: got illegal,req=%b want 10", {illegal, wr_req}); end
  endtask

  task automatic test_timeout();
    int early;
    apply_reset();
    for (int i = 0; i < 12; i++) do_move(3'(i % 2), 1'b0);
    early = 0;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      if (timeout || wr_req) early++;
    end
    vectors++; if (early !== 0) begin errors++; $display("FAIL timeout_early: got %0d early cycles want 0", early); end
    @(negedge clk);
    vectors++; if ({timeout, wr_req} !== 2'b11) begin errors++; $display("FAIL timeout_fire: got timeout,req=%b want 11", {timeout, wr_req}); end
    vectors++; if ({wr_row, wr_col, wr_val} !== {3'd0, 3'd2, 2'b01}) begin errors++;
      $display("FAIL timeout_fields: got %h want %h", {wr_row, wr_col, wr_val}, {3'd0, 3'd2, 2'b01}); end
    @(negedge clk);
    vectors++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width: got %b want 0", timeout); end
    ack_write();
    finish_check(1'b0);
    vectors++; if ({move_count, cur_player} !== {6'd13, 2'b10}) begin errors++;
      $display("FAIL timeout_after: got count=%0d player=%b want 13 10", move_count, cur_player); end
  endtask

  task automatic test_win_and_clear();
    int pulses;
    apply_reset();
    do_move(3'd0, 1'b0);
    do_move(3'd1, 1'b1);
    vectors++; if ({game_over, winner} !== 3'b110) begin errors++; $display("FAIL win_state: got over,winner=%b want 110", {game_over, winner}); end
    vectors++; if (cur_player !== 2'b10) begin errors++; $display("FAIL win_player: got %b want 10", cur_player); end
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (timeout || !game_over) pulses++;
    end
    vectors++; if (pulses !== 0) begin errors++; $display("FAIL done_frozen: got %0d bad cycles want 0", pulses); end
    press_btn(3'd4);
    vectors++; if ({clr_req, game_over} !== 2'b10) begin errors++; $display("FAIL clr_req: got req,over=%b want 10", {clr_req, game_over}); end
    clr_ack = 1'b1;
    @(negedge clk); clr_ack = 1'b0;
    vectors++; if ({clr_req, move_count, cur_player, winner} !== {1'b0, 6'd0, 2'b01, 2'b00}) begin errors++;
      $display("FAIL clr_done: got req=%b count=%0d player=%b winner=%b want 0 0 01 00", clr_req, move_count, cur_player, winner); end
    press_btn(3'd0);
    vectors++; if ({wr_req, wr_row, wr_val} !== {1'b1, 3'd0, 2'b01}) begin errors++;
      $display("FAIL clr_heights: got req=%b row=%0d val=%b want 1 0 01", wr_req, wr_row, wr_val); end
    ack_write();
    finish_check(1'b0);
  endtask

  task automatic test_draw();
    int bad;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 42; i++) begin
      press_btn(3'(i / 6));
      if ({wr_req, wr_row, wr_col} !== {1'b1, 3'(i % 6), 3'(i / 6)}) bad++;
      ack_write();
      finish_check(1'b0);
      if (i == 40) begin
        vectors++; if (game_over !== 1'b0) begin errors++; $display("FAIL draw_early_over: got %b want 0", game_over); end
      end
    end
    vectors++; if (bad !== 0) begin errors++; $display("FAIL draw_writes: got %0d bad writes want 0", bad); end
    vectors++; if ({game_over, winner, move_count} !== {1'b1, 2'b00, 6'd42}) begin errors++;
      $display("FAIL draw_end: got over=%b winner=%b count=%0d want 1 00 42", game_over, winner, move_count); end
  endtask

  task automatic test_back_to_back_stall();
    int unstable;
    int spurious;
    apply_reset();
    press_btn(3'd5);
    unstable = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 1) begin column = 3'd2; load_btn = 1'b1; end
      if (c == 3) load_btn = 1'b0;
      if ({wr_req, wr_row, wr_col, wr_val} !== {1'b1, 3'd0, 3'd5, 2'b01}) unstable++;
    end
    vectors++; if (unstable !== 0) begin errors++; $display("FAIL stall_stable: got %0d unstable cycles want 0", unstable); end
    ack_write();
    finish_check(1'b0);
    spurious = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (wr_req || illegal) spurious++;
    end
    vectors++; if (spurious !== 0) begin errors++; $display("FAIL stall_press_queued: got %0d cycles want 0", spurious); end
    press_btn(3'd5);
    vectors++; if ({wr_req, wr_row, wr_col, wr_val} !== {1'b1, 3'd1, 3'd5, 2'b10}) begin errors++;
      $display("FAIL stall_second: got req=%b row=%0d col=%0d val=%b want 1 1 5 10", wr_req, wr_row, wr_col, wr_val); end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    vectors++; if (wr_req !== 1'b0) begin errors++; $display("FAIL async_rst_req: got %b want 0", wr_req); end
    vectors++; if ({cur_player, move_count, wr_row, wr_col, wr_val} !== {2'b01, 6'd0, 3'd0, 3'd0, 2'b00}) begin errors++;
      $display("FAIL async_rst_vals: got player=%b count=%0d row=%0d col=%0d val=%b want 01 0 0 0 00",
               cur_player, move_count, wr_row, wr_col, wr_val); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_column_fill();
    test_timeout();
    test_win_and_clear();
    test_draw();
    test_back_to_back_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/connect4_turn_ctrl.md
# connect4_turn_ctrl

Turn sequencer for the Connect4 game. Converts a column selection plus the `load_btn` press into a legal piece drop, writes it to the board storage over a request/acknowledge port, and triggers the win checker. It alternates players, enforces a per-turn timeout and detects draws. It also handles board clearing for a new game. It sits between the user inputs (switches and button) and the board/win-check datapath inside `Connect4`.

## Interface
- `TURN_TIMEOUT`, default 500_000_000: cycles allowed per turn before an auto-move; 0 disables the timeout.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset. The clock is `clk` and the reset is `rst`; reset is asynchronous and active-low.
- `column` in 3: selected column; 0..6 legal, 7 illegal.
- `load_btn` in 1: raw drop button, asynchronous to `clk`.
- `wr_req` out 1: board write request.
- `wr_row` out 3: target row, 0 = bottom.
- `wr_col` out 3: target column.
- `wr_val` out 2: cell value to write.
- `wr_ack` in 1: board accepted the write.
- `clr_req` out 1: board clear request.
- `clr_ack` in 1: board cleared.
- `chk_start` out 1: one-cycle pulse that starts the win check at (`wr_row`, `wr_col`).
- `chk_done` in 1: win check finished.
- `chk_win` in 1: win found; valid only with `chk_done`.
- `cur_player` out 2: player to move; 2'b01 = P1, 2'b10 = P2.
- `move_count` out 6: pieces on the board, 0..42.
- `illegal` out 1: one-cycle pulse when a drop is rejected.
- `timeout` out 1: one-cycle pulse when an auto-move is issued.
- `game_over` out 1: high in the DONE state.
- `winner` out 2: 00 = none or draw, 01 = P1, 10 = P2.

## Operation
- Cell encoding: 00 empty, 01 P1, 10 P2. The board is 6 rows × 7 columns.
- Internal state: seven 3-bit column heights (0..6), `move_count`, turn timer, and latched row/column.
- Button: `load_btn` passes through a 2-flop synchronizer plus rising-edge detector, giving one `press` pulse per press. There is no debounce; upstream handles it.
- FSM states: WAIT_MOVE, WRITE, CHECK, DONE, CLEAR.
- Reset puts the FSM in WAIT_MOVE and clears all heights, `move_count` and the timer. Reset values of outputs:
  - `cur_player` = 01.
  - `winner` = 00.
  - `wr_row`, `wr_col`, `wr_val` = 0.
  - All strobes and requests = 0.
- WAIT_MOVE:
  - `press` with `column` = 7, or with a column at height 6: pulse `illegal`, stay in WAIT_MOVE, and do not reset the timer.
  - `press` with a legal column: latch `wr_col` = `column`, `wr_row` = height, `wr_val` = `cur_player`; go to WRITE.
  - Timer reaches `TURN_TIMEOUT`-1 with no `press`: pulse `timeout`, pick the lowest-index non-full column, and proceed as a legal press. A non-full column always exists in WAIT_MOVE because `move_count` < 42 there.
  - `press` and timer expiry in the same cycle: `press` wins.
- WRITE: hold `wr_req` high with stable `wr_row`/`wr_col`/`wr_val` until `wr_ack` is sampled high. In that cycle, increment the height and `move_count`, then go to CHECK.
- CHECK: assert `chk_start` for the first cycle only, then wait for `chk_done`. On `chk_done`:
  - `chk_win`: set `winner` = `cur_player` and go to DONE.
  - Else, if `move_count` = 42: set `winner` = 00 and go to DONE (draw).
  - Else: toggle `cur_player`, clear the timer, and go to WAIT_MOVE.
- DONE: `game_over` = 1 and the timer is frozen. `press` goes to CLEAR.
- CLEAR: hold `clr_req` until `clr_ack`. In the ack cycle, reset heights, `move_count`, `winner`, `cur_player` = 01 and the timer, then go to WAIT_MOVE.
- `press` in WRITE, CHECK or CLEAR is dropped, not queued.
- Reset asserted mid-handshake aborts it immediately. The board is not cleared by this block on reset.

## Timing
- `load_btn` first sampled high at edge k: `press` is valid in the cycle after edge k+1. The FSM samples `column` and transitions at edge k+2, so `wr_req` or `illegal` is high after edge k+2.
- `column` must be stable from edge k+1 through k+2.
- `wr_ack` may arrive in the same cycle `wr_req` rises, giving a minimum WRITE length of 1 cycle. There is no upper bound.
- `chk_start` rises one cycle after the `wr_ack` cycle. The minimum CHECK length is 1 cycle after `chk_start`, since `chk_done` may come in the cycle after `chk_start`.
- The timer increments every cycle in WAIT_MOVE and saturates at expiry. Its width is `$clog2(TURN_TIMEOUT+1)`.
- `cur_player` changes at the same edge that leaves CHECK.

## Structure
- `connect4_pkg` holds:
  - `cell_t` (EMPTY, P1, P2).
  - `ROWS` = 6, `COLS` = 7, `MAX_MOVES` = 42.
  - The `turn_state_t` enum.
  - This package is shared with the board and the win checker.
- Sub-module `connect4_btn_sync` implements the 2-flop synchronizer plus rising-edge pulse, and is reused for any future buttons.

## Test plan
- Reset, then press with `column` = 3 and ack immediately: `wr_row`=0, `wr_col`=3, `wr_val`=01; `chk_start` one cycle after the ack. With `chk_win`=0, `cur_player`=10 and `move_count`=1.
- Seven presses on column 0 with alternating players: the first six write rows 0..5. The seventh pulses `illegal` with no `wr_req`, and `cur_player` is unchanged. A press with `column` = 7 also gives `illegal`.
- `TURN_TIMEOUT`=20, columns 0–1 full, no press: `timeout` pulses after 20 cycles and `wr_col`=2 is written.
- Return `chk_win`=1 on P2's move: `game_over`=1, `winner`=10. Further press → `clr_req`; on `clr_ack`, `move_count`=0, `cur_player`=01.
- Fill 42 moves with `chk_win` always 0: after move 42, `game_over`=1 and `winner`=00.
- Hold off `wr_ack` for 10 cycles with presses during WRITE: the request fields stay stable and the extra presses are ignored. Asserting `rst` low mid-WRITE drops `wr_req` asynchronously and returns to the reset values.
